// File: rtl/lock_entry_ssd.sv
// Keypad code-entry lock controller driving a four-digit active-low
// seven-segment vector for the downstream VGA renderer.
module lock_entry_ssd #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned FAIL_CYCLES    = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear,
  input  logic        enter,
  output logic [27:0] ssdLINES,
  output logic        unlocked,
  output logic        alarm,
  output logic [2:0]  tries
);

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned SEG_W   = 7;

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;
  localparam logic [27:0]      DISP_DASH = 28'hFDFBF7E;
  localparam logic [27:0]      DISP_OPEN = {7'b0000001, 7'b0011000, 7'b0110000, 7'b1101010};
  localparam logic [27:0]      DISP_ERR  = {7'b0110000, 7'b1111010, 7'b1111010, 7'b1111111};
  localparam logic [27:0]      DISP_LOC  = {7'b1110001, 7'b0000001, 7'b0110001, 7'b1111111};

  localparam logic [TIMER_W-1:0] FAIL_LAST = TIMER_W'(FAIL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]         TRY_MAX   = 3'(MAX_TRIES);

  logic [1:0]         state, state_d;
  logic [2:0]         count, count_d;
  logic [15:0]        code_buf, code_d;
  logic [2:0]         tries_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic [27:0]        ssd_d;

  // BCD digit to active-low ABCDEFG pattern
  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ENTRY;
      count    <= 3'd0;
      code_buf <= 16'h0000;
      tries    <= 3'd0;
      timer    <= '0;
      ssdLINES <= DISP_DASH;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      code_buf <= code_d;
      tries    <= tries_d;
      timer    <= timer_d;
      ssdLINES <= ssd_d;
      unlocked <= (state_d == ST_OPEN);
      alarm    <= (state_d == ST_LOCKOUT);
    end
  end

  // Next-state, entry buffer, try counter, timer and display selection
  always_comb begin
    state_d = state;
    count_d = count;
    code_d  = code_buf;
    tries_d = tries;
    timer_d = '0;
    ssd_d   = DISP_DASH;

    case (state)
      ST_ENTRY: begin
        if (clear) begin
          count_d = 3'd0;
        end else if (enter) begin
          if (count == 3'd4) begin
            if (code_buf == CODE) begin
              state_d = ST_OPEN;
              tries_d = 3'd0;
            end else begin
              tries_d = tries + 3'd1;
              state_d = (tries_d >= TRY_MAX) ? ST_LOCKOUT : ST_FAIL;
            end
            count_d = 3'd0;
          end
        end else if (digit_valid && (digit <= 4'd9) && (count < 3'd4)) begin
          case (count[1:0])
            2'd0:    code_d[15:12] = digit;
            2'd1:    code_d[11:8]  = digit;
            2'd2:    code_d[7:4]   = digit;
            default: code_d[3:0]   = digit;
          endcase
          count_d = count + 3'd1;
        end
      end
      ST_OPEN: begin
        if (clear || enter) begin
          state_d = ST_ENTRY;
          count_d = 3'd0;
        end
      end
      ST_FAIL: begin
        if (timer == FAIL_LAST) begin
          state_d = ST_ENTRY;
          count_d = 3'd0;
        end
      end
      default: begin
        if (timer == LOCK_LAST) begin
          state_d = ST_ENTRY;
          count_d = 3'd0;
          tries_d = 3'd0;
        end
      end
    endcase

    // Timer runs only while a timed state persists; any state change clears it
    if ((state_d == state) && ((state == ST_FAIL) || (state == ST_LOCKOUT))) begin
      timer_d = timer + TIMER_W'(1);
    end

    case (state_d)
      ST_OPEN:    ssd_d = DISP_OPEN;
      ST_FAIL:    ssd_d = DISP_ERR;
      ST_LOCKOUT: ssd_d = DISP_LOC;
      default: begin
        for (int k = 0; k < 4; k++) begin
          ssd_d[27-7*k -: 7] = (3'(k) < count_d) ? seg7(code_d[15-4*k -: 4]) : SEG_DASH;
        end
      end
    endcase
  end

endmodule

// File: doc/lock_entry_ssd.md
Name: lock_entry_ssd

Overview:
Keypad-entry and lock-control stage that sits directly upstream of the VGA seven-segment renderer. It collects four decimal digits and compares them with a fixed code. It runs the lock state machine: entry, open, fail and lockout. Its output is the 28-bit active-low segment vector `ssdLINES` that the renderer draws as four on-screen digits.

Parameters:
- CODE, 16'h1234, unlock code as four BCD nibbles; [15:12] is the first digit entered.
- MAX_TRIES, 3, number of consecutive failed attempts that triggers lockout (range 1..7).
- FAIL_CYCLES, 50_000_000, clk cycles the FAIL state is held.
- LOCKOUT_CYCLES, 500_000_000, clk cycles the LOCKOUT state is held.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- digit_valid  in  1  single-cycle strobe: `digit` is valid
- digit  in  4  digit value; 0..9 accepted, 10..15 ignored
- clear  in  1  single-cycle strobe: discard the entry / relock
- enter  in  1  single-cycle strobe: submit the entry
- ssdLINES  out  28  segments, active-low (0 = lit); digit k (k=0 leftmost) at [27-7k : 21-7k], bit order within a digit {A,B,C,D,E,F,G}
- unlocked  out  1  high while in OPEN
- alarm  out  1  high while in LOCKOUT
- tries  out  3  consecutive failed-attempt count

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high at a clk edge resets the block. All outputs are registered.
- Reset values: state=ENTRY, count=0, tries=0, unlocked=0, alarm=0, ssdLINES=28'hFDFBF7E (four dashes). Reset in any state, including mid-timer, aborts to these values.
- Latency: an input strobe sampled at edge N updates state and every output at edge N+1.
- Same-cycle priority in ENTRY: clear > enter > digit_valid. The lower-priority strobes are dropped.

State ENTRY:
- digit_valid with digit<=9 and count<4: store the digit at position `count`, then count++.
- digit>9 or count==4: the strobe is ignored.
- clear: count=0.
- enter with count<4: ignored.
- enter with count==4 and buffer==CODE: go to OPEN, tries=0.
- enter with count==4 and buffer!=CODE: tries++. If the new tries==MAX_TRIES, go to LOCKOUT; otherwise go to FAIL.
- Display: filled positions show their digit, unfilled positions show a dash (1111110).

State OPEN:
- unlocked=1. Display "OPEn" = 0000001,0011000,0110000,1101010.
- clear or enter: go to ENTRY with count=0.
- digit_valid: ignored.

State FAIL:
- Display "Err " = 0110000,1111010,1111010,1111111.
- All strobes are ignored.
- After exactly FAIL_CYCLES cycles, go to ENTRY with count=0.

State LOCKOUT:
- alarm=1. Display "LOC " = 1110001,0000001,0110001,1111111.
- All strobes are ignored.
- After LOCKOUT_CYCLES cycles, go to ENTRY with count=0 and tries=0.

Timer and counters:
- Timer is 32-bit, cleared on every state entry, compared with (param − 1).
- tries never exceeds MAX_TRIES.

Digit encoding (active-low ABCDEFG):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100

Test Plan:
1. Reset: hold rst one cycle -> ssdLINES=28'hFDFBF7E, unlocked=0, alarm=0, tries=0.
2. Digits 1,2,3,4 -> after "1", [27:21]=1001111 and the rest are dashes. After all four, ssdLINES = 1001111_0010010_0000110_1001100. A 5th digit (7) leaves it unchanged. enter -> next cycle unlocked=1 and display OPEn. clear -> ENTRY with dashes.
3. Digits 1,2,3,5 then enter (FAIL_CYCLES=4) -> Err display for exactly 4 cycles, tries=1, then dashes. Same cycle as a digit strobe with digit=12 -> ignored. enter with count=2 -> ignored.
4. MAX_TRIES=3, LOCKOUT_CYCLES=8, three wrong codes -> after the 3rd, alarm=1 and display LOC. digit/enter strobes during lockout have no effect. After 8 cycles, alarm=0, tries=0, dashes.
5. clear, enter and digit_valid asserted in the same cycle with count=4 and a correct buffer -> clear wins: count=0, no unlock.
6. rst asserted mid-FAIL and mid-LOCKOUT -> next cycle shows the reset values. A subsequent correct code unlocks normally.
